// File: rtl/seg7_pkg.sv
// Shared constants for the active-low 7-segment display path (bit 6 = a ... bit 0 = g).
// The display-side decoder and the scan capture receiver both use these patterns and codes.
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMMIT,
    ST_DWELL
  } scan_state_e;
endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational active-low segment pattern to 4-bit code decoder.
// Blank decodes to CODE_BLANK without error; anything unrecognised is CODE_INVALID with o_err set.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_err
);

  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    o_code = CODE_INVALID;
    o_err  = 1'b1;
    case (i_seg)
      SEG_0:     begin o_code = 4'd0;       o_err = 1'b0; end
      SEG_1:     begin o_code = 4'd1;       o_err = 1'b0; end
      SEG_2:     begin o_code = 4'd2;       o_err = 1'b0; end
      SEG_3:     begin o_code = 4'd3;       o_err = 1'b0; end
      SEG_4:     begin o_code = 4'd4;       o_err = 1'b0; end
      SEG_5:     begin o_code = 4'd5;       o_err = 1'b0; end
      SEG_6:     begin o_code = 4'd6;       o_err = 1'b0; end
      SEG_7:     begin o_code = 4'd7;       o_err = 1'b0; end
      SEG_8:     begin o_code = 4'd8;       o_err = 1'b0; end
      SEG_9:     begin o_code = 4'd9;       o_err = 1'b0; end
      SEG_BLANK: begin o_code = CODE_BLANK; o_err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers digit codes from a multiplexed active-low 7-segment bus: waits for each pattern
// to settle, commits it into the slot selected by the anode, and emits one frame per full scan.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture_en,
  input  logic [DIGITS-1:0]   anode_n,
  input  logic [6:0]          display7,
  output logic [4*DIGITS-1:0] frame_value,
  output logic                frame_valid,
  output logic                frame_error,
  output logic [DIGITS-1:0]   digit_err
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

  logic [DIGITS-1:0]   r_s_an, r_p_an;
  logic [6:0]          r_s_seg, r_p_seg;
  logic [CNT_W-1:0]    r_cnt;
  scan_state_e         r_state, w_next_state;
  logic [DIGITS-1:0]   r_seen, r_slot_err;
  logic [4*DIGITS-1:0] r_slot_code;
  logic [DIGITS-1:0]   w_sel;
  logic [3:0]          w_dec_code;
  logic                w_dec_err, w_change, w_an_valid, w_settled, w_write, w_frame_done;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_s_an  <= '1;
      r_s_seg <= SEG_BLANK;
      r_p_an  <= '1;
      r_p_seg <= SEG_BLANK;
    end else begin
      r_s_an  <= anode_n;
      r_s_seg <= display7;
      r_p_an  <= r_s_an;
      r_p_seg <= r_s_seg;
    end
  end

  assign w_change     = (r_s_an != r_p_an) || (r_s_seg != r_p_seg);
  assign w_sel        = ~r_s_an;
  assign w_an_valid   = ($countones(w_sel) == 1);
  // The commit edge is the one on which cnt reaches STABLE_CYCLES-1; a change on that edge wins.
  assign w_settled    = (r_state == ST_SETTLE) && !w_change && (r_cnt == CNT_PRE) && capture_en;
  assign w_write      = w_settled && w_an_valid;
  assign w_frame_done = &r_seen;

  seg7_pattern_decoder u_decoder (
    .i_seg  (r_s_seg),
    .o_code (w_dec_code),
    .o_err  (w_dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst || r_state == ST_IDLE || !capture_en || w_change) r_cnt <= '0;
    else if (r_cnt != CNT_MAX)                                r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (capture_en) w_next_state = ST_SETTLE;
      ST_SETTLE: if (w_settled)  w_next_state = ST_COMMIT;
      ST_COMMIT:                 w_next_state = ST_DWELL;
      ST_DWELL:  if (w_change)   w_next_state = ST_SETTLE;
      default:                   w_next_state = ST_IDLE;
    endcase
    if (!capture_en) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == ST_IDLE) begin
      r_seen      <= '0;
      r_slot_code <= '0;
      r_slot_err  <= '0;
    end else if (w_frame_done) begin
      r_seen <= '0;
    end else if (w_write) begin
      r_seen <= r_seen | w_sel;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_sel[i]) begin
          r_slot_code[4*i +: 4] <= w_dec_code;
          r_slot_err[i]         <= w_dec_err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_value <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      digit_err   <= '0;
    end else begin
      frame_valid <= w_frame_done;
      if (w_frame_done) begin
        frame_value <= r_slot_code;
        digit_err   <= r_slot_err;
        frame_error <= |r_slot_err;
      end
    end
  end

endmodule
